// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding, default
// operand width and the bit-counter width helper.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the serial adder datapath.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic cout
);

  assign sum  = A ^ B ^ Cin;
  assign cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a single full_adder.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port for a - b via two's complement.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum, fa_cout;
  logic [WIDTH:0]   r_cat;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; the forced carry-in replaces cin.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  full_adder u_fa (
    .A   (a_q[0]),
    .B   (b_q[0]),
    .Cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts r_q holds the result.
  assign r_cat = {fa_sum, r_q};

  // NOTE: every next-state signal gets a hold default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        r_d     = r_cat[WIDTH:1];
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = r_cat[WIDTH:1];
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected
// results, a monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int W     = 8;
  localparam int LIMIT = 40;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;
  exp_t         sb_q[$];
  logic [W-1:0] held_sum  = '0;
  logic         held_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, subtraction as a - b with no-borrow flag.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t r;
    int unsigned t;
    if (s) begin
      r.sum  = W'(x - y);
      r.cout = (x >= y);
    end else begin
      t      = int'(x) + int'(y) + int'(c);
      r.sum  = t[W-1:0];
      r.cout = t[W];
    end
    return r;
  endfunction

  // Monitor: result compare on done, hold check while busy.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && busy) begin
      check("sum_hold", 32'(sum), 32'(held_sum));
      check("cout_hold", 32'(cout), 32'(held_cout));
    end
    if (!rst && done) begin
      n_done++;
      check("done_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        held_sum  = e.sum;
        held_cout = e.cout;
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic si, input int glitch);
    int k, busy_cnt, done_before;
    logic seen;
    @(negedge clk);
    a = ai; b = bi; cin = ci; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = si;
`endif
    sb_q.push_back(model(ai, bi, ci, si));
    done_before = n_done;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    busy_cnt = busy ? 1 : 0;
    seen = done;
    while (!seen && k < LIMIT) begin
      if (k == glitch) begin
        a = 8'hFF; start = 1'b1;
      end else if (glitch != 0 && k == glitch + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (busy) busy_cnt++;
      seen = done;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(k), 32'(W + 1));
      check("busy_cycles", 32'(busy_cnt), 32'(W));
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_count", 32'(n_done), 32'(done_before + 1));
  endtask

  initial begin
    logic si;
    int n_before;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic si;
    int n_before;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    run_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h5A, 8'h3C, 1'b1, 1'b0, 0);

    // Start pulsed and operand changed mid-RUN must be ignored.
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 3);
    n_before = n_done;
    repeat (W + 3) @(negedge clk);
    check("no_restart_done", 32'(n_done), 32'(n_before));
    check("no_restart_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    sb_q.delete();
    held_sum = '0;
    held_cout = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      si = 1'($urandom_range(0, 1));
`else
      si = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), si, 0);
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
